alu_seq: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle datapath ALU. It adds RV32M-style multiply, divide and remainder, plus XOR and signed/unsigned compares, behind a valid/ready handshake on both sides. It sits in the execute stage; the pipeline stalls on `in_ready`/`out_valid`. Basic ops take one cycle, and multiply/divide iterate one bit per cycle.

---
 rtl/alu_seq_if.sv | 41 ++++
 rtl/alu_seq.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_if
//  Description : Request/response bundle for the multi-cycle execute ALU.
//                master : issuing pipeline stage (drives request, consumes
//                         result).
//                slave  : the ALU itself.
//  Signals     : in_valid/in_ready  request handshake
//                a, b, opcode       operands and operation
//                flush              synchronous abort
//                out_valid/out_ready response handshake
//                result, status     registered result and {n,z,c,v}
//                busy               iterating (MUL or DIV)
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_seq_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   opcode;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic [3:0]   status;
    logic         busy;

    modport master (
        output in_valid, a, b, opcode, flush, out_ready,
        input  in_ready, out_valid, result, status, busy
    );

    modport slave (
        input  in_valid, a, b, opcode, flush, out_ready,
        output in_ready, out_valid, result, status, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Multi-cycle execute-stage ALU. Basic ops (add/sub/logic/
//                compares) complete in one cycle; multiply and divide iterate
//                one bit per cycle behind valid/ready handshakes.
//  Ports       : clk   rising-edge clock
//                rst   asynchronous active-high reset
//                bus   alu_seq_if.slave (request, response, flush, busy)
//  Revision    : 1.0  initial release
// ============================================================================
module alu_seq #(
    parameter int N = 32
) (
    input  wire logic  clk,
    input  wire logic  rst,
    alu_seq_if.slave   bus
);

    localparam int            CW       = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    // MUL: {partial product high half, remaining multiplier bits}
    // DIV: {partial remainder, dividend bits shifting out / quotient in}
    logic [2*N-1:0] acc_q;
    // MUL: multiplicand; DIV: divisor magnitude
    logic [N-1:0]   opnd_q;
    // MUL: select high half; DIV: select remainder
    logic           sel_q;
    logic           negq_q;
    logic           negr_q;
    logic [N-1:0]   result_q;
    logic [3:0]     status_q;
    logic           out_valid_q;
    logic           busy_q;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    logic w_accept;

    assign bus.in_ready  = !bus.flush &&
                           ((state_q == S_IDLE) ||
                            ((state_q == S_DONE) && bus.out_ready));
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.status    = status_q;
    assign bus.busy      = busy_q;

    function automatic logic [3:0] nz_flags(input logic [N-1:0] r);
        return {r[N-1], (r == '0), 2'b00};
    endfunction

    // ------------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------------
    logic [N:0]   w_sum;
    logic [N:0]   w_diff;
    logic [N-1:0] w_basic_res;
    logic [3:0]   w_basic_st;

    assign w_sum  = {1'b0, bus.a} + {1'b0, bus.b};
    // Top bit of the extended difference is the borrow (a < b unsigned).
    assign w_diff = {1'b0, bus.a} - {1'b0, bus.b};

    always_comb begin
        logic c;
        logic v;
        w_basic_res = '0;
        c           = 1'b0;
        v           = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                w_basic_res = w_sum[N-1:0];
                c           = w_sum[N];
                v           = (bus.a[N-1] == bus.b[N-1]) &&
                              (w_sum[N-1] != bus.a[N-1]);
            end
            OP_SUB: begin
                w_basic_res = w_diff[N-1:0];
                c           = w_diff[N];
                v           = (bus.a[N-1] != bus.b[N-1]) &&
                              (w_diff[N-1] != bus.a[N-1]);
            end
            OP_AND:  w_basic_res = bus.a & bus.b;
            OP_OR:   w_basic_res = bus.a | bus.b;
            OP_XOR:  w_basic_res = bus.a ^ bus.b;
            OP_SLT:  w_basic_res = {{(N-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: w_basic_res = {{(N-1){1'b0}}, (bus.a < bus.b)};
            // Undefined codes fall through to zero, which yields status 0100.
            default: w_basic_res = '0;
        endcase
        w_basic_st = {w_basic_res[N-1], (w_basic_res == '0), c, v};
    end

    // ------------------------------------------------------------------------
    // Divide set-up: operand magnitudes and the non-iterating special cases
    // ------------------------------------------------------------------------
    logic         w_div_signed;
    logic         w_a_neg;
    logic         w_b_neg;
    logic [N-1:0] w_a_mag;
    logic [N-1:0] w_b_mag;
    logic         w_div_zero;
    logic         w_div_ovf;
    logic         w_div_special;
    logic [N-1:0] w_spec_res;

    assign w_div_signed  = bus.opcode[1];
    assign w_a_neg       = w_div_signed && bus.a[N-1];
    assign w_b_neg       = w_div_signed && bus.b[N-1];
    assign w_a_mag       = w_a_neg ? (~bus.a + 1'b1) : bus.a;
    assign w_b_mag       = w_b_neg ? (~bus.b + 1'b1) : bus.b;
    assign w_div_zero    = (bus.b == '0);
    assign w_div_ovf     = w_div_signed &&
                           (bus.a == {1'b1, {(N-1){1'b0}}}) &&
                           (bus.b == {N{1'b1}});
    assign w_div_special = w_div_zero || w_div_ovf;

    // opcode[0] selects the remainder.
    always_comb begin
        w_spec_res = '0;
        if (w_div_zero) begin
            w_spec_res = bus.opcode[0] ? bus.a : {N{1'b1}};
        end else begin
            w_spec_res = bus.opcode[0] ? '0 : bus.a;
        end
    end

    // ------------------------------------------------------------------------
    // Multiply step: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    // ------------------------------------------------------------------------
    logic [N:0]     w_mul_sum;
    logic [2*N-1:0] w_mul_acc;
    logic [N-1:0]   w_mul_res;

    assign w_mul_sum = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign w_mul_acc = {w_mul_sum, acc_q[N-1:1]};
    assign w_mul_res = sel_q ? w_mul_acc[2*N-1:N] : w_mul_acc[N-1:0];

    // ------------------------------------------------------------------------
    // Restoring divide step: shift the next dividend bit into the partial
    // remainder, trial-subtract the divisor, keep the difference if it did
    // not go negative.
    // ------------------------------------------------------------------------
    logic [N:0]     w_div_part;
    logic [N:0]     w_div_trial;
    logic [2*N-1:0] w_div_acc;
    logic [N-1:0]   w_quot;
    logic [N-1:0]   w_rem;
    logic [N-1:0]   w_div_res;

    assign w_div_part  = acc_q[2*N-1:N-1];
    assign w_div_trial = w_div_part - {1'b0, opnd_q};
    assign w_div_acc   = w_div_trial[N]
                       ? {w_div_part[N-1:0],  acc_q[N-2:0], 1'b0}
                       : {w_div_trial[N-1:0], acc_q[N-2:0], 1'b1};
    assign w_quot      = negq_q ? (~w_div_acc[N-1:0]   + 1'b1) : w_div_acc[N-1:0];
    assign w_rem       = negr_q ? (~w_div_acc[2*N-1:N] + 1'b1) : w_div_acc[2*N-1:N];
    assign w_div_res   = sel_q ? w_rem : w_quot;

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            opnd_q      <= '0;
            sel_q       <= 1'b0;
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
            result_q    <= '0;
            status_q    <= 4'b0000;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (bus.flush) begin
            // Abort wins over acceptance and completion; partial state is
            // simply abandoned and overwritten by the next iterative op.
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        if (bus.opcode[3:1] == 3'b100) begin
                            acc_q       <= {{N{1'b0}}, bus.b};
                            opnd_q      <= bus.a;
                            sel_q       <= bus.opcode[0];
                            cnt_q       <= CNT_LAST;
                            state_q     <= S_MUL;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b1;
                        end else if (bus.opcode[3:2] == 2'b11) begin
                            if (w_div_special) begin
                                result_q    <= w_spec_res;
                                status_q    <= nz_flags(w_spec_res);
                                state_q     <= S_DONE;
                                out_valid_q <= 1'b1;
                            end else begin
                                acc_q       <= {{N{1'b0}}, w_a_mag};
                                opnd_q      <= w_b_mag;
                                sel_q       <= bus.opcode[0];
                                negq_q      <= w_a_neg ^ w_b_neg;
                                negr_q      <= w_a_neg;
                                cnt_q       <= CNT_LAST;
                                state_q     <= S_DIV;
                                out_valid_q <= 1'b0;
                                busy_q      <= 1'b1;
                            end
                        end else begin
                            result_q    <= w_basic_res;
                            status_q    <= w_basic_st;
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                        end
                    end else if ((state_q == S_DONE) && bus.out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end

                S_MUL: begin
                    acc_q <= w_mul_acc;
                    if (cnt_q == '0) begin
                        result_q    <= w_mul_res;
                        status_q    <= nz_flags(w_mul_res);
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                S_DIV: begin
                    acc_q <= w_div_acc;
                    if (cnt_q == '0) begin
                        result_q    <= w_div_res;
                        status_q    <= nz_flags(w_div_res);
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Scoreboard bench for alu_seq. Stimulus pushes expected
//                responses from an arithmetic reference model; a monitor
//                pops and compares whenever the DUT presents a result.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_seq;

    localparam int N = 32;

    typedef struct {
        logic [N-1:0] res;
        logic [3:0]   st;
        int           lat;
        int           busy;
        int           k;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_fail;
    int   busy_cnt;
    bit   presented;
    bit   rnd_done;
    exp_t q[$];

    alu_seq_if #(.N(N)) bus ();

    alu_seq #(.N(N)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: results from plain arithmetic on the operation rules.
    function automatic exp_t model(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t                  e;
        logic [N-1:0]          r;
        logic                  c;
        logic                  v;
        logic signed [N:0]     wide;
        logic [2*N-1:0]        p;
        logic signed [N-1:0]   sa;
        logic signed [N-1:0]   sb;
        logic [N-1:0]          smin;
        sa   = a;
        sb   = b;
        smin = {1'b1, {(N-1){1'b0}}};
        r = '0; c = 1'b0; v = 1'b0;
        e.lat = 1; e.busy = 0;
        p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        case (op)
            4'b0000: begin
                r = a + b;
                c = ({1'b0, a} + {1'b0, b}) > {1'b0, {N{1'b1}}};
                wide = $signed({a[N-1], a}) + $signed({b[N-1], b});
                v = (wide != $signed({r[N-1], r}));
            end
            4'b0001: begin
                r = a - b;
                c = (a < b);
                wide = $signed({a[N-1], a}) - $signed({b[N-1], b});
                v = (wide != $signed({r[N-1], r}));
            end
            4'b0010: r = a & b;
            4'b0011: r = a | b;
            4'b0100: r = a ^ b;
            4'b0101: r = (sa < sb) ? 1 : 0;
            4'b0110: r = (a < b) ? 1 : 0;
            4'b1000: begin r = p[N-1:0];   e.lat = N + 1; e.busy = N; end
            4'b1001: begin r = p[2*N-1:N]; e.lat = N + 1; e.busy = N; end
            4'b1100: if (b == 0) r = '1; else begin r = a / b; e.lat = N + 1; e.busy = N; end
            4'b1101: if (b == 0) r = a;  else begin r = a % b; e.lat = N + 1; e.busy = N; end
            4'b1110: begin
                if (b == 0) r = '1;
                else if (a == smin && b == '1) r = a;
                else begin r = sa / sb; e.lat = N + 1; e.busy = N; end
            end
            4'b1111: begin
                if (b == 0) r = a;
                else if (a == smin && b == '1) r = '0;
                else begin r = sa % sb; e.lat = N + 1; e.busy = N; end
            end
            default: r = '0;
        endcase
        e.res = r;
        e.st  = {r[N-1], (r == 0), c, v};
        e.k   = 0;
        return e;
    endfunction

    // Called just after a falling edge; returns just after the next falling
    // edge following acceptance, with in_valid dropped.
    task automatic issue(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         output int waits);
        exp_t e;
        waits = 0;
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.a        = a;
        bus.b        = b;
        #1;
        while (!bus.in_ready) begin
            @(negedge clk);
            #1;
            waits++;
            if (waits > 400) begin
                n_cmp++;
                n_fail++;
                $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 400 cycles");
                bus.in_valid = 1'b0;
                return;
            end
        end
        e   = model(op, a, b);
        e.k = cyc + 1;
        q.push_back(e);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", q.size(), 0);
    endtask

    function automatic logic [N-1:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return {{(N-1){1'b0}}, 1'b1};
            2: return '1;
            3: return {1'b1, {(N-1){1'b0}}};
            4: return {1'b0, {(N-1){1'b1}}};
            5: return N'($urandom_range(0, 255));
            default: return N'($urandom);
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------------
    initial begin
        presented = 1'b0;
        busy_cnt  = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                presented = 1'b0;
                busy_cnt  = 0;
            end else begin
                if (q.size() == 0) busy_cnt = 0;
                else if (bus.busy) busy_cnt++;
                if (!bus.out_valid) begin
                    presented = 1'b0;
                end else if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: out_valid=1 result=%0h with nothing outstanding", bus.result);
                end else begin
                    if (!presented) begin
                        presented = 1'b1;
                        check("latency", cyc - q[0].k, q[0].lat - 1);
                        check("busy_cycles", busy_cnt, q[0].busy);
                        busy_cnt = 0;
                    end
                    check("result", bus.result, q[0].res);
                    check("status", bus.status, q[0].st);
                    if (bus.out_ready) begin
                        void'(q.pop_front());
                        presented = 1'b0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int w;
        n_cmp = 0;
        n_fail = 0;
        rnd_done = 1'b0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.opcode = 4'h0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_result", bus.result, 0);
        check("rst_status", bus.status, 0);
        @(negedge clk);

        // ADD / SUB with flag corner cases
        bus.out_ready = 1'b1;
        issue(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, w);
        issue(4'b0001, 32'h0000_0000, 32'h0000_0001, w);
        drain();

        // Back-to-back basic ops: in_ready must never drop
        issue(4'b0010, 32'hF0F0_1234, 32'h0FF0_FF00, w); check("stream_wait_and", w, 0);
        issue(4'b0011, 32'hF0F0_1234, 32'h0FF0_FF00, w); check("stream_wait_or", w, 0);
        issue(4'b0100, 32'hF0F0_1234, 32'h0FF0_FF00, w); check("stream_wait_xor", w, 0);
        issue(4'b0101, 32'hFFFF_FFFF, 32'h0000_0001, w); check("stream_wait_slt", w, 0);
        drain();

        // Multiply
        issue(4'b1000, 32'hFFFF_FFFF, 32'h0000_0002, w);
        issue(4'b1001, 32'hFFFF_FFFF, 32'h0000_0002, w);
        drain();

        // Divide, including the non-iterating special cases
        issue(4'b1110, 32'hFFFF_FFF9, 32'h0000_0002, w);
        issue(4'b1111, 32'hFFFF_FFF9, 32'h0000_0002, w);
        issue(4'b1100, 32'd100, 32'd7, w);
        issue(4'b1110, 32'h1234_5678, 32'h0000_0000, w);
        issue(4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, w);
        issue(4'b1111, 32'h8000_0000, 32'hFFFF_FFFF, w);
        issue(4'b0111, 32'h1234_5678, 32'h1, w);
        drain();

        // Back-pressure on a completed DIVU
        bus.out_ready = 1'b0;
        issue(4'b1100, 32'd1000, 32'd3, w);
        w = 0;
        while (!bus.out_valid && w < 100) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("bp_out_valid", bus.out_valid, 1);
        repeat (5) begin
            @(negedge clk);
            #1;
            check("bp_in_ready_low", bus.in_ready, 0);
            check("bp_held_valid", bus.out_valid, 1);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        check("bp_in_ready_release", bus.in_ready, 1);
        @(negedge clk);
        drain();

        // Flush partway through a DIV
        issue(4'b1110, 32'h7654_3210, 32'h0000_0013, w);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        q.delete();
        #1;
        check("flush_in_ready", bus.in_ready, 0);
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        check("flush_out_valid", bus.out_valid, 0);
        check("flush_busy", bus.busy, 0);
        check("flush_idle_ready", bus.in_ready, 1);
        repeat (40) @(negedge clk);
        issue(4'b0000, 32'h0000_1111, 32'h0000_2222, w);
        drain();

        // Asynchronous reset partway through a MUL
        issue(4'b1000, 32'h0001_2345, 32'h0000_0777, w);
        repeat (5) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        q.delete();
        check("arst_busy", bus.busy, 0);
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_result", bus.result, 0);
        check("arst_status", bus.status, 0);
        check("arst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        issue(4'b0001, 32'h8000_0000, 32'h0000_0001, w);
        drain();

        // Randomised traffic with random back-pressure
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    issue(4'($urandom_range(0, 15)), rnd_opnd(), rnd_opnd(), w);
                    if ($urandom_range(0, 3) == 0) @(negedge clk);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
